// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator display path.
package calc_pkg;

   // Glyph codes held in the display registers: 0-9 are decimal digits.
   typedef logic [3:0] glyph_t;

   localparam glyph_t GlyphMinus = 4'hA;
   localparam glyph_t GlyphE     = 4'hB;
   localparam glyph_t GlyphBlank = 4'hF;

   // Conversion FSM encoding.
   typedef logic [1:0] state_t;

   localparam state_t StIdle    = 2'd0;
   localparam state_t StConvert = 2'd1;
   localparam state_t StCommit  = 2'd2;

   // Active-low {g,f,e,d,c,b,a} pattern for a glyph code.
   function automatic logic [6:0] glyph_to_seg(input glyph_t g);
      logic [6:0] seg;
      case (g)
         4'd0:       seg = 7'b1000000;
         4'd1:       seg = 7'b1111001;
         4'd2:       seg = 7'b0100100;
         4'd3:       seg = 7'b0110000;
         4'd4:       seg = 7'b0011001;
         4'd5:       seg = 7'b0010010;
         4'd6:       seg = 7'b0000010;
         4'd7:       seg = 7'b1111000;
         4'd8:       seg = 7'b0000000;
         4'd9:       seg = 7'b0010000;
         GlyphMinus: seg = 7'b0111111;
         GlyphE:     seg = 7'b0000110;
         default:    seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   // 10^n, used for elaboration-time overflow limits.
   function automatic int unsigned pow10(input int unsigned n);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p;
   endfunction

endpackage

// File: rtl/calc_display_driver_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
module bin2bcd_seq #(
   parameter int unsigned VALUE_W  = 14,
   parameter int unsigned N_DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [VALUE_W-1:0]    bin,
   output logic                  done,
   output logic [4*N_DIGITS-1:0] bcd
);

   localparam int unsigned BcdW = 4 * N_DIGITS;
   localparam int unsigned CntW = $clog2(VALUE_W + 1);

   logic [VALUE_W-1:0] shift_q, shift_d;
   logic [BcdW-1:0]    bcd_q, bcd_d, bcd_adj;
   logic [CntW-1:0]    cnt_q, cnt_d;

   // Add 3 to every nibble that would reach 10 or more after the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Load on start, otherwise shift one binary bit into the BCD accumulator per cycle.
   always_comb begin
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      if (start) begin
         shift_d = bin;
         bcd_d   = '0;
         cnt_d   = CntW'(VALUE_W);
      end else if (cnt_q != '0) begin
         bcd_d   = (bcd_adj << 1) | BcdW'(shift_q[VALUE_W-1]);
         shift_d = shift_q << 1;
         cnt_d   = cnt_q - CntW'(1);
      end
   end

   // Converter state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   // done marks the cycle whose clock edge performs the final iteration;
   // bcd holds the full result from the following cycle on.
   assign done = (cnt_q == CntW'(1));
   assign bcd  = bcd_q;

endmodule

// File: rtl/calc_display_driver.sv
// Converts a signed binary result into multiplexed active-low 7-segment drive.
module calc_display_driver
   import calc_pkg::*;
#(
   parameter int unsigned N_DIGITS    = 4,
   parameter int unsigned VALUE_W     = 14,
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [VALUE_W-1:0]  value,
   input  logic                negative,
   input  logic                load,
   input  logic                blank,
   output logic                busy,
   output logic                overflow,
   output logic [N_DIGITS-1:0] anodes,
   output logic [6:0]          segments,
   output logic                dp
);

   localparam int unsigned BcdW = 4 * N_DIGITS;
   localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [31:0] MaxPos = 32'(pow10(N_DIGITS) - 1);
   localparam logic [31:0] MaxNeg = 32'(pow10(N_DIGITS - 1) - 1);

   state_t              state_q, state_d;
   logic                start, conv_done;
   logic [BcdW-1:0]     bcd;
   logic                neg_q, ovf_pend_q, overflow_q, ovf_now;
   logic [31:0]         value_ext;
   glyph_t              disp_q [N_DIGITS];
   glyph_t              fmt    [N_DIGITS];
   logic [IdxW-1:0]     msd;
   logic                any_nz;
   logic [CntW-1:0]     ref_cnt_q;
   logic [IdxW-1:0]     idx_q;
   glyph_t              sel;
   logic [N_DIGITS-1:0] anodes_q, anodes_d;
   logic [6:0]          segments_q, segments_d;

   bin2bcd_seq #(
      .VALUE_W  (VALUE_W),
      .N_DIGITS (N_DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (value),
      .done  (conv_done),
      .bcd   (bcd)
   );

   // Overflow is decided from the raw input at load time.
   assign value_ext = 32'(value);
   assign ovf_now   = negative ? (value_ext > MaxNeg) : (value_ext > MaxPos);

   // Conversion sequencing; load is only honoured while idle.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               start   = 1'b1;
               state_d = StConvert;
            end
         end
         StConvert: if (conv_done) state_d = StCommit;
         StCommit:  state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Build the glyph image: blanking, minus placement, or the overflow E.
   always_comb begin
      msd    = '0;
      any_nz = 1'b0;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if (bcd[4*i +: 4] != 4'd0) begin
            msd    = IdxW'(i);
            any_nz = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         fmt[i] = (IdxW'(i) <= msd) ? glyph_t'(bcd[4*i +: 4]) : GlyphBlank;
      end
      // Negative zero shows a plain 0; negatives never fill the top digit.
      if (neg_q && any_nz && (msd != IdxW'(N_DIGITS - 1))) begin
         fmt[msd + IdxW'(1)] = GlyphMinus;
      end
      if (ovf_pend_q) begin
         for (int unsigned i = 0; i < N_DIGITS; i++) begin
            fmt[i] = GlyphBlank;
         end
         fmt[N_DIGITS-1] = GlyphE;
      end
   end

   // FSM, load capture and display commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         neg_q      <= 1'b0;
         ovf_pend_q <= 1'b0;
         overflow_q <= 1'b0;
         for (int unsigned i = 0; i < N_DIGITS; i++) begin
            disp_q[i] <= GlyphBlank;
         end
      end else begin
         state_q <= state_d;
         if (start) begin
            neg_q      <= negative;
            ovf_pend_q <= ovf_now;
         end
         if (state_q == StCommit) begin
            overflow_q <= ovf_pend_q;
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
               disp_q[i] <= fmt[i];
            end
         end
      end
   end

   // Refresh timer: advance the selected digit every REFRESH_DIV cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_cnt_q <= '0;
         idx_q     <= '0;
      end else if (ref_cnt_q == CntW'(REFRESH_DIV - 1)) begin
         ref_cnt_q <= '0;
         idx_q     <= (idx_q == IdxW'(N_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
      end else begin
         ref_cnt_q <= ref_cnt_q + CntW'(1);
      end
   end

   // Drive the selected digit unless it is blank or the display is blanked.
   always_comb begin
      sel        = disp_q[idx_q];
      anodes_d   = '1;
      segments_d = 7'h7F;
      if (!blank && (sel != GlyphBlank)) begin
         anodes_d[idx_q] = 1'b0;
         segments_d      = glyph_to_seg(sel);
      end
   end

   // Registered pin drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         anodes_q   <= '1;
         segments_q <= 7'h7F;
      end else begin
         anodes_q   <= anodes_d;
         segments_q <= segments_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign overflow = overflow_q;
   assign anodes   = anodes_q;
   assign segments = segments_q;
   assign dp       = 1'b1;

endmodule
